// File: rtl/tft_panel_interface_pkg.sv
// ---------------------------------------------------------------------------
// tft_panel_interface_pkg
// Shared definitions for the TFT panel output stage:
//   - panel_state_t : power / video sequencing states of the panel FSM
//   - expand_colour : MSB-aligned bit replication from a core colour depth
//                     to a (wider or equal) panel colour depth
//   - max3          : helper for sizing the shared cycle counter
// ---------------------------------------------------------------------------
package tft_panel_interface_pkg;

    typedef enum logic [2:0] {
        ST_OFF        = 3'd0,
        ST_RAIL_UP    = 3'd1,
        ST_RESET_HOLD = 3'd2,
        ST_SETTLE     = 3'd3,
        ST_ACTIVE     = 3'd4,
        ST_BLANK      = 3'd5,
        ST_RAIL_DOWN  = 3'd6
    } panel_state_t;

    // Widest colour channel the replication helper handles.
    localparam int unsigned MAX_DEPTH = 32;

    // Repeats the in_depth-bit value from the MSB downwards until out_depth
    // bits are filled; any partial final copy keeps only its upper bits.
    // The result is right-aligned in the returned vector.
    function automatic logic [MAX_DEPTH-1:0] expand_colour(
        input logic [MAX_DEPTH-1:0] value,
        input int unsigned          in_depth,
        input int unsigned          out_depth
    );
        logic [MAX_DEPTH-1:0] result;
        logic [4:0]           dst_bit;
        logic [4:0]           src_bit;
        result = '0;
        for (int unsigned k = 0; k < MAX_DEPTH; k++) begin
            if (k < out_depth) begin
                dst_bit = 5'(out_depth - 1 - k);
                src_bit = 5'(in_depth - 1 - (k % in_depth));
                result[dst_bit] = value[src_bit];
            end
        end
        return result;
    endfunction

    function automatic int unsigned max3(
        input int unsigned a,
        input int unsigned b,
        input int unsigned c
    );
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tft_panel_interface_colour_expand.sv
// ---------------------------------------------------------------------------
// tft_colour_expand
// One register stage carrying syncs, data enable and three colour channels
// to the panel. Colours are widened by MSB-aligned replication. While
// 'blank' is high the stage loads idle values instead (syncs high, de low,
// colours zero), so syncs, de and colours always share the same latency.
//
// Ports:
//   clk, rst_n                 pixel clock, asynchronous active-low reset
//   blank                      1 = load idle values this cycle
//   hsync, vsync, de           core timing (syncs active low)
//   red, green, blue           core colour, IN_DEPTH bits each
//   tft_hsync, tft_vsync, tft_de   registered timing to panel
//   tft_red, tft_green, tft_blue   registered colour, OUT_DEPTH bits each
// ---------------------------------------------------------------------------
module tft_colour_expand
    import tft_panel_interface_pkg::*;
#(
    parameter int unsigned IN_DEPTH  = 4,
    parameter int unsigned OUT_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 blank,
    input  logic                 hsync,
    input  logic                 vsync,
    input  logic                 de,
    input  logic [IN_DEPTH-1:0]  red,
    input  logic [IN_DEPTH-1:0]  green,
    input  logic [IN_DEPTH-1:0]  blue,
    output logic                 tft_hsync,
    output logic                 tft_vsync,
    output logic                 tft_de,
    output logic [OUT_DEPTH-1:0] tft_red,
    output logic [OUT_DEPTH-1:0] tft_green,
    output logic [OUT_DEPTH-1:0] tft_blue
);

    logic hsync_reg;
    logic vsync_reg;
    logic de_reg;

    logic [IN_DEPTH-1:0] chan_in [3];

    assign chan_in[0] = red;
    assign chan_in[1] = green;
    assign chan_in[2] = blue;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
            de_reg    <= 1'b0;
        end else if (blank) begin
            hsync_reg <= 1'b1;
            vsync_reg <= 1'b1;
            de_reg    <= 1'b0;
        end else begin
            hsync_reg <= hsync;
            vsync_reg <= vsync;
            de_reg    <= de;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
        logic [OUT_DEPTH-1:0] chan_next;
        logic [OUT_DEPTH-1:0] chan_reg;

        assign chan_next = OUT_DEPTH'(expand_colour(MAX_DEPTH'(chan_in[gi]),
                                                    IN_DEPTH, OUT_DEPTH));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                chan_reg <= '0;
            end else if (blank) begin
                chan_reg <= '0;
            end else begin
                chan_reg <= chan_next;
            end
        end
    end

    assign tft_hsync = hsync_reg;
    assign tft_vsync = vsync_reg;
    assign tft_de    = de_reg;
    assign tft_red   = g_chan[0].chan_reg;
    assign tft_green = g_chan[1].chan_reg;
    assign tft_blue  = g_chan[2].chan_reg;

endmodule

// File: rtl/tft_panel_interface.sv
// ---------------------------------------------------------------------------
// tft_panel_interface
// Panel output stage between the video core and the TFT pins. Sequences the
// panel power rails up (rail 0 first) and down (rail 0 last), controls panel
// reset, and only lets video through while the panel is fully powered and a
// whole frame can be shown. Colour is widened from IN_DEPTH to OUT_DEPTH by
// bit replication in a single register stage.
//
// Parameters: RAILS, STEP_CYCLES (>=1), RESET_CYCLES (>=1),
//             SETTLE_FRAMES (>=1), BLANK_TIMEOUT (>=1),
//             IN_DEPTH, OUT_DEPTH (1 <= IN_DEPTH <= OUT_DEPTH <= 32)
//
// Ports:
//   i_pixel_clk               pixel clock, the only clock
//   i_reset_n                 asynchronous active-low reset (emergency off)
//   i_enable                  level request, 1 = panel on
//   i_hsync, i_vsync, i_de    core timing (syncs active low)
//   i_red, i_green, i_blue    core colour
//   o_pwr_rails               rail enables, 1 = on
//   o_tft_reset_n             panel reset, active low
//   o_tft_hsync/vsync/de      timing to panel, 1-cycle latency
//   o_tft_red/green/blue      expanded colour to panel, 1-cycle latency
//   o_ready                   1 only while in ACTIVE
// ---------------------------------------------------------------------------
module tft_panel_interface
    import tft_panel_interface_pkg::*;
#(
    parameter int unsigned RAILS         = 5,
    parameter int unsigned STEP_CYCLES   = 51000,
    parameter int unsigned RESET_CYCLES  = 510000,
    parameter int unsigned SETTLE_FRAMES = 2,
    parameter int unsigned BLANK_TIMEOUT = 1000000,
    parameter int unsigned IN_DEPTH      = 4,
    parameter int unsigned OUT_DEPTH     = 8
) (
    input  logic                 i_pixel_clk,
    input  logic                 i_reset_n,
    input  logic                 i_enable,
    input  logic                 i_hsync,
    input  logic                 i_vsync,
    input  logic                 i_de,
    input  logic [IN_DEPTH-1:0]  i_red,
    input  logic [IN_DEPTH-1:0]  i_green,
    input  logic [IN_DEPTH-1:0]  i_blue,
    output logic [RAILS-1:0]     o_pwr_rails,
    output logic                 o_tft_reset_n,
    output logic                 o_tft_hsync,
    output logic                 o_tft_vsync,
    output logic                 o_tft_de,
    output logic [OUT_DEPTH-1:0] o_tft_red,
    output logic [OUT_DEPTH-1:0] o_tft_green,
    output logic [OUT_DEPTH-1:0] o_tft_blue,
    output logic                 o_ready
);

    localparam int unsigned CNT_MAX = max3(STEP_CYCLES, RESET_CYCLES, BLANK_TIMEOUT);
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned FW      = $clog2(SETTLE_FRAMES + 1);
    localparam int unsigned RIW     = (RAILS > 1) ? $clog2(RAILS) : 1;

    localparam logic [CW-1:0]  STEP_LAST    = CW'(STEP_CYCLES - 1);
    localparam logic [CW-1:0]  RESET_LAST   = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0]  TIMEOUT_LAST = CW'(BLANK_TIMEOUT - 1);
    localparam logic [FW-1:0]  SETTLE_LAST  = FW'(SETTLE_FRAMES - 1);
    localparam logic [RIW-1:0] RAIL_LAST    = RIW'(RAILS - 1);

    // An abort is seen one cycle after i_enable drops, so the step counter
    // starts one cycle ahead: the first rail then clears STEP_CYCLES after
    // the drop itself.
    localparam logic [CW-1:0]  ABORT_LOAD   = (STEP_CYCLES > 1) ? CW'(1) : '0;

    panel_state_t   state_reg;
    logic [CW-1:0]  count_reg;
    logic [FW-1:0]  frame_cnt_reg;
    logic [RIW-1:0] rail_idx_reg;
    logic [RAILS-1:0] rails_reg;
    logic           tft_reset_n_reg;
    logic           ready_reg;
    logic           vsync_prev_reg;

    logic [RIW-1:0] rail_idx_inc;
    logic           frame_start;
    logic           settle_done;
    logic           blank_timeout;
    logic           pass_video;

    assign rail_idx_inc  = rail_idx_reg + RIW'(1);
    assign frame_start   = vsync_prev_reg & ~i_vsync;
    assign settle_done   = (state_reg == ST_SETTLE) & i_enable & frame_start &
                           (frame_cnt_reg >= SETTLE_LAST);
    assign blank_timeout = (count_reg >= TIMEOUT_LAST);

    // The frame start that finishes SETTLE is already shown so the panel gets
    // the frame from its vsync edge; in BLANK the frame start (or a timeout)
    // is the first cycle that is no longer shown.
    assign pass_video = (state_reg == ST_ACTIVE) | settle_done |
                        ((state_reg == ST_BLANK) & ~frame_start & ~blank_timeout);

    always_ff @(posedge i_pixel_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg       <= ST_OFF;
            count_reg       <= '0;
            frame_cnt_reg   <= '0;
            rail_idx_reg    <= '0;
            rails_reg       <= '0;
            tft_reset_n_reg <= 1'b0;
            ready_reg       <= 1'b0;
            vsync_prev_reg  <= 1'b1;
        end else begin
            vsync_prev_reg <= i_vsync;
            case (state_reg)
                ST_OFF: begin
                    if (i_enable) begin
                        rails_reg[0]  <= 1'b1;
                        rail_idx_reg  <= '0;
                        count_reg     <= '0;
                        frame_cnt_reg <= '0;
                        state_reg     <= (RAILS == 1) ? ST_RESET_HOLD : ST_RAIL_UP;
                    end
                end

                ST_RAIL_UP: begin
                    if (!i_enable) begin
                        tft_reset_n_reg <= 1'b0;
                        count_reg       <= ABORT_LOAD;
                        state_reg       <= ST_RAIL_DOWN;
                    end else if (count_reg >= STEP_LAST) begin
                        rails_reg[rail_idx_inc] <= 1'b1;
                        rail_idx_reg            <= rail_idx_inc;
                        count_reg               <= '0;
                        // The reset hold time runs from the moment the last
                        // rail switches on.
                        if (rail_idx_inc == RAIL_LAST) begin
                            state_reg <= ST_RESET_HOLD;
                        end
                    end else begin
                        count_reg <= count_reg + CW'(1);
                    end
                end

                ST_RESET_HOLD: begin
                    if (!i_enable) begin
                        tft_reset_n_reg <= 1'b0;
                        count_reg       <= ABORT_LOAD;
                        state_reg       <= ST_RAIL_DOWN;
                    end else if (count_reg >= RESET_LAST) begin
                        tft_reset_n_reg <= 1'b1;
                        count_reg       <= '0;
                        frame_cnt_reg   <= '0;
                        state_reg       <= ST_SETTLE;
                    end else begin
                        count_reg <= count_reg + CW'(1);
                    end
                end

                ST_SETTLE: begin
                    if (!i_enable) begin
                        tft_reset_n_reg <= 1'b0;
                        count_reg       <= ABORT_LOAD;
                        state_reg       <= ST_RAIL_DOWN;
                    end else if (settle_done) begin
                        ready_reg     <= 1'b1;
                        count_reg     <= '0;
                        frame_cnt_reg <= '0;
                        state_reg     <= ST_ACTIVE;
                    end else if (frame_start) begin
                        frame_cnt_reg <= frame_cnt_reg + FW'(1);
                    end
                end

                ST_ACTIVE: begin
                    if (!i_enable) begin
                        ready_reg <= 1'b0;
                        count_reg <= '0;
                        state_reg <= ST_BLANK;
                    end
                end

                ST_BLANK: begin
                    if (frame_start || blank_timeout) begin
                        tft_reset_n_reg <= 1'b0;
                        count_reg       <= '0;
                        state_reg       <= ST_RAIL_DOWN;
                    end else begin
                        count_reg <= count_reg + CW'(1);
                    end
                end

                ST_RAIL_DOWN: begin
                    // rail_idx_reg always points at the highest rail still on.
                    if (count_reg >= STEP_LAST) begin
                        rails_reg[rail_idx_reg] <= 1'b0;
                        count_reg               <= '0;
                        if (rail_idx_reg == '0) begin
                            state_reg <= ST_OFF;
                        end else begin
                            rail_idx_reg <= rail_idx_reg - RIW'(1);
                        end
                    end else begin
                        count_reg <= count_reg + CW'(1);
                    end
                end

                default: begin
                    rails_reg       <= '0;
                    tft_reset_n_reg <= 1'b0;
                    ready_reg       <= 1'b0;
                    count_reg       <= '0;
                    state_reg       <= ST_OFF;
                end
            endcase
        end
    end

    tft_colour_expand #(
        .IN_DEPTH  (IN_DEPTH),
        .OUT_DEPTH (OUT_DEPTH)
    ) u_colour_expand (
        .clk       (i_pixel_clk),
        .rst_n     (i_reset_n),
        .blank     (~pass_video),
        .hsync     (i_hsync),
        .vsync     (i_vsync),
        .de        (i_de),
        .red       (i_red),
        .green     (i_green),
        .blue      (i_blue),
        .tft_hsync (o_tft_hsync),
        .tft_vsync (o_tft_vsync),
        .tft_de    (o_tft_de),
        .tft_red   (o_tft_red),
        .tft_green (o_tft_green),
        .tft_blue  (o_tft_blue)
    );

    assign o_pwr_rails   = rails_reg;
    assign o_tft_reset_n = tft_reset_n_reg;
    assign o_ready       = ready_reg;

endmodule

// File: tb/tb_tft_panel_interface.sv
module tb_tft_panel_interface;

    localparam int RAILS   = 5;
    localparam int STEP    = 4;
    localparam int RST_CYC = 8;
    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 20;

    typedef logic [53:0] vid_t;

    typedef struct {
        logic       hs;
        logic       de;
        logic [3:0] r, g, b;
        logic [4:0] r5, g5, b5;
        logic [7:0] er, eg, eb;
        logic [7:0] er5, eg5, eb5;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, enable, hs, vs, de;
    logic [3:0] r, g, b;
    logic [4:0] r5, g5, b5;

    logic [RAILS-1:0] rails, rails5;
    logic tft_rst_n, tft_rst_n5, ready, ready5;
    logic o_hs, o_vs, o_de, o5_hs, o5_vs, o5_de;
    logic [7:0] o_r, o_g, o_b, o5_r, o5_g, o5_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    vid_t sb_q[$];
    vec_t vecs[4];

    always #5 clk = ~clk;

    tft_panel_interface #(
        .RAILS(RAILS), .STEP_CYCLES(STEP), .RESET_CYCLES(RST_CYC),
        .SETTLE_FRAMES(SETTLE), .BLANK_TIMEOUT(TIMEOUT),
        .IN_DEPTH(4), .OUT_DEPTH(8)
    ) dut (
        .i_pixel_clk(clk), .i_reset_n(rst_n), .i_enable(enable),
        .i_hsync(hs), .i_vsync(vs), .i_de(de),
        .i_red(r), .i_green(g), .i_blue(b),
        .o_pwr_rails(rails), .o_tft_reset_n(tft_rst_n),
        .o_tft_hsync(o_hs), .o_tft_vsync(o_vs), .o_tft_de(o_de),
        .o_tft_red(o_r), .o_tft_green(o_g), .o_tft_blue(o_b),
        .o_ready(ready)
    );

    tft_panel_interface #(
        .RAILS(RAILS), .STEP_CYCLES(STEP), .RESET_CYCLES(RST_CYC),
        .SETTLE_FRAMES(SETTLE), .BLANK_TIMEOUT(TIMEOUT),
        .IN_DEPTH(5), .OUT_DEPTH(8)
    ) dut5 (
        .i_pixel_clk(clk), .i_reset_n(rst_n), .i_enable(enable),
        .i_hsync(hs), .i_vsync(vs), .i_de(de),
        .i_red(r5), .i_green(g5), .i_blue(b5),
        .o_pwr_rails(rails5), .o_tft_reset_n(tft_rst_n5),
        .o_tft_hsync(o5_hs), .o_tft_vsync(o5_vs), .o_tft_de(o5_de),
        .o_tft_red(o5_r), .o_tft_green(o5_g), .o_tft_blue(o5_b),
        .o_ready(ready5)
    );

    // Widening model: append whole copies, then drop surplus LSBs.
    function automatic logic [7:0] exp_expand(input logic [7:0] v, input int in_d);
        logic [31:0] acc;
        int fill;
        acc = '0;
        fill = 0;
        while (fill < 8) begin
            acc = (acc << in_d) | 32'(v);
            fill += in_d;
        end
        return 8'(acc >> (fill - 8));
    endfunction

    function automatic vid_t make_exp(input logic pass, input logic h, input logic v,
                                      input logic d, input logic [7:0] er, input logic [7:0] eg,
                                      input logic [7:0] eb, input logic [7:0] er5,
                                      input logic [7:0] eg5, input logic [7:0] eb5);
        if (pass) return {h, v, d, er, eg, eb, h, v, d, er5, eg5, eb5};
        return {3'b110, 24'h0, 3'b110, 24'h0};
    endfunction

    function automatic logic [4:0] therm(input int n);
        return 5'((1 << n) - 1);
    endfunction

    function automatic logic [4:0] up_rails(input int k);
        int n;
        if (k < 1) return 5'b0;
        n = (k - 1) / STEP + 1;
        if (n > RAILS) n = RAILS;
        return therm(n);
    endfunction

    function automatic vid_t act_vid();
        return {o_hs, o_vs, o_de, o_r, o_g, o_b, o5_hs, o5_vs, o5_de, o5_r, o5_g, o5_b};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_pwr(input logic [4:0] er, input logic erst);
        chk("rails", 64'(rails), 64'(er));
        chk("rails5", 64'(rails5), 64'(er));
        chk("tft_reset_n", 64'(tft_rst_n), 64'(erst));
        chk("tft_reset_n5", 64'(tft_rst_n5), 64'(erst));
    endtask

    task automatic chk_ready(input logic e);
        chk("ready", 64'(ready), 64'(e));
        chk("ready5", 64'(ready5), 64'(e));
    endtask

    task automatic tick();
        vid_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("video", 64'(act_vid()), 64'(e));
        end
    endtask

    task automatic px(input logic hs_i, input logic vs_i, input logic de_i,
                      input logic [3:0] r_i, input logic [3:0] g_i, input logic [3:0] b_i,
                      input logic [4:0] r5_i, input logic [4:0] g5_i, input logic [4:0] b5_i,
                      input logic pass);
        hs = hs_i; vs = vs_i; de = de_i;
        r = r_i; g = g_i; b = b_i;
        r5 = r5_i; g5 = g5_i; b5 = b5_i;
        sb_q.push_back(make_exp(pass, hs_i, vs_i, de_i,
            exp_expand(8'(r_i), 4), exp_expand(8'(g_i), 4), exp_expand(8'(b_i), 4),
            exp_expand(8'(r5_i), 5), exp_expand(8'(g5_i), 5), exp_expand(8'(b5_i), 5)));
    endtask

    task automatic px_rand(input logic vs_i, input logic pass);
        px(1'($urandom), vs_i, 1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
           5'($urandom), 5'($urandom), 5'($urandom), pass);
    endtask

    task automatic powerup_check(input int kmax);
        for (int k = 1; k <= kmax; k++) begin
            px_rand(1'b1, 1'b0);
            tick();
            chk_pwr(up_rails(k), (k >= STEP * (RAILS - 1) + 1 + RST_CYC) ? 1'b1 : 1'b0);
        end
    endtask

    task automatic settle_to_active();
        repeat (3) begin px_rand(1'b1, 1'b0); tick(); end
        px_rand(1'b0, 1'b0); tick();
        px_rand(1'b0, 1'b0); tick();
        chk_ready(1'b0);
        repeat (4) begin px_rand(1'b1, 1'b0); tick(); end
        chk_ready(1'b0);
        px_rand(1'b0, 1'b1); tick();
        chk_ready(1'b1);
        px_rand(1'b0, 1'b1); tick();
        chk_pwr(5'b11111, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 4'hA, 4'h3, 4'hF, 5'h16, 5'h1F, 5'h00, 8'hAA, 8'h33, 8'hFF, 8'hB5, 8'hFF, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 5'h01, 5'h10, 5'h0A, 8'h00, 8'h00, 8'h00, 8'h08, 8'h84, 8'h52};
        vecs[2] = '{1'b1, 1'b1, 4'h5, 4'hC, 4'h1, 5'h1F, 5'h16, 5'h01, 8'h55, 8'hCC, 8'h11, 8'hFF, 8'hB5, 8'h08};
        vecs[3] = '{1'b1, 1'b1, 4'h8, 4'h7, 4'hE, 5'h0A, 5'h01, 5'h10, 8'h88, 8'h77, 8'hEE, 8'h52, 8'h08, 8'h84};

        rst_n = 1'b0; enable = 1'b0;
        hs = 1'b1; vs = 1'b1; de = 1'b0;
        r = '0; g = '0; b = '0; r5 = '0; g5 = '0; b5 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_pwr(5'b0, 1'b0);
        chk("video_reset", 64'(act_vid()), 64'(make_exp(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0)));
        chk_ready(1'b0);

        // Power-up from cycle 0, then settle to ACTIVE
        rst_n = 1'b1;
        enable = 1'b1;
        powerup_check(25);
        settle_to_active();

        // Colour path table
        for (int i = 0; i < 4; i++) begin
            hs = vecs[i].hs; vs = 1'b1; de = vecs[i].de;
            r = vecs[i].r; g = vecs[i].g; b = vecs[i].b;
            r5 = vecs[i].r5; g5 = vecs[i].g5; b5 = vecs[i].b5;
            sb_q.push_back(make_exp(1'b1, vecs[i].hs, 1'b1, vecs[i].de,
                vecs[i].er, vecs[i].eg, vecs[i].eb, vecs[i].er5, vecs[i].eg5, vecs[i].eb5));
            tick();
            $display("vec %0d r=%0h g=%0h b=%0h -> %0h %0h %0h | r5=%0h -> %0h",
                     i, vecs[i].r, vecs[i].g, vecs[i].b, o_r, o_g, o_b, vecs[i].r5, o5_r);
        end
        repeat (8) begin px_rand(1'b1, 1'b1); tick(); end
        chk_ready(1'b1);

        // Power-down mid-frame: video runs to the next vsync fall
        enable = 1'b0;
        px_rand(1'b1, 1'b1); tick();
        chk_ready(1'b0);
        chk_pwr(5'b11111, 1'b1);
        repeat (5) begin px_rand(1'b1, 1'b1); tick(); end
        chk_pwr(5'b11111, 1'b1);
        px_rand(1'b0, 1'b0); tick();
        chk_pwr(5'b11111, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            px_rand(1'b1, 1'b0); tick();
            chk_pwr(therm(RAILS - k / STEP), 1'b0);
        end
        chk_ready(1'b0);

        // Abort while rails = 00111, re-raise at +2
        enable = 1'b1;
        for (int k = 1; k <= 47; k++) begin
            logic [4:0] er;
            px_rand(1'b1, 1'b0); tick();
            if (k <= 10) er = up_rails(k);
            else if (k <= 13) er = 5'b00111;
            else if (k <= 17) er = 5'b00011;
            else if (k <= 21) er = 5'b00001;
            else if (k == 22) er = 5'b00000;
            else er = up_rails(k - 22);
            chk_pwr(er, (k >= 47) ? 1'b1 : 1'b0);
            if (k == 10) enable = 1'b0;
            if (k == 12) enable = 1'b1;
        end
        settle_to_active();

        // Missing vsync: BLANK exits on timeout
        enable = 1'b0;
        for (int k = 1; k <= 41; k++) begin
            px_rand(1'b1, (k <= TIMEOUT) ? 1'b1 : 1'b0); tick();
            chk_pwr((k < 25) ? 5'b11111 : therm(RAILS - (k - 21) / STEP),
                    (k < 21) ? 1'b1 : 1'b0);
        end
        chk_ready(1'b0);

        // Asynchronous reset pulse during RESET_HOLD
        enable = 1'b1;
        powerup_check(20);
        #3;
        rst_n = 1'b0;
        #1;
        chk_pwr(5'b0, 1'b0);
        chk("video_async", 64'(act_vid()), 64'(make_exp(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0, 8'h0)));
        chk_ready(1'b0);
        sb_q.delete();
        repeat (2) begin px_rand(1'b1, 1'b0); tick(); end
        chk_pwr(5'b0, 1'b0);
        rst_n = 1'b1;
        powerup_check(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tft_panel_interface.md
Name: tft_panel_interface

Overview:
Parametrised panel output stage between the video core and the TFT pins.
- Sequences N panel power rails up and down in a fixed order.
- Controls panel reset.
- Gates video so the panel only sees whole frames while fully powered.
- Expands core colour depth to panel depth by bit replication, registered.
- Replaces the fixed 4-to-8 replication wiring and unused power pins at the top level.

Parameters:
- RAILS, 5, number of power rails. Rail 0 is enabled first and disabled last.
- STEP_CYCLES, 51000, pixel clocks between consecutive rail switches (1 ms at 51 MHz). Must be ≥1.
- RESET_CYCLES, 510000, pixel clocks after the last rail comes up before panel reset is released. Must be ≥1.
- SETTLE_FRAMES, 2, frame starts after reset release before video is passed. Must be ≥1.
- BLANK_TIMEOUT, 1000000, maximum pixel clocks to wait for a frame start when blanking.
- IN_DEPTH, 4, core colour bits per channel. Must satisfy 1 ≤ IN_DEPTH ≤ OUT_DEPTH.
- OUT_DEPTH, 8, panel colour bits per channel.

Ports:
- i_pixel_clk  in  1  pixel clock; the only clock.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_enable  in  1  level request: 1 = panel on.
- i_hsync  in  1  core hsync, active low.
- i_vsync  in  1  core vsync, active low.
- i_de  in  1  core data enable.
- i_red, i_green, i_blue  in  IN_DEPTH each  core colour.
- o_pwr_rails  out  RAILS  rail enables, 1 = on.
- o_tft_reset_n  out  1  panel reset, active low.
- o_tft_hsync, o_tft_vsync  out  1 each  to panel, active low.
- o_tft_de  out  1  to panel.
- o_tft_red, o_tft_green, o_tft_blue  out  OUT_DEPTH each  to panel.
- o_ready  out  1  1 only in ACTIVE.

Behaviour:
- Reset values: o_pwr_rails = 0, o_tft_reset_n = 0, hsync = vsync = 1, de = 0, colours = 0, o_ready = 0. State is OFF; counters are 0.
- Frame start: falling edge of i_vsync, detected against a 1-cycle registered copy. The registered copy resets to 1.
- States and transitions:
  - OFF: rails all off. When i_enable = 1, go to RAIL_UP with rail index = 0.
  - RAIL_UP: set rail[index] on the entry cycle, then count STEP_CYCLES. When index reaches RAILS-1 and the count expires, go to RESET_HOLD.
  - RESET_HOLD: count RESET_CYCLES, then set o_tft_reset_n = 1 and go to SETTLE.
  - SETTLE: count frame starts. On the SETTLE_FRAMES-th frame start, go to ACTIVE; that same cycle is the first pass-through input cycle.
  - ACTIVE: video passes through; o_ready = 1.
  - BLANK: entered from ACTIVE when i_enable = 0. Video stays passed until the next frame start, or until BLANK_TIMEOUT cycles elapse. Then outputs go inactive, reset is asserted, and the state moves to RAIL_DOWN.
  - RAIL_DOWN: clear the highest on rail every STEP_CYCLES, reverse order. When all rails are off, go to OFF.
- i_enable dropping in RAIL_UP, RESET_HOLD or SETTLE:
  - Assert reset immediately.
  - Go to RAIL_DOWN starting from the highest rail already on.
  - The first rail clears STEP_CYCLES after the drop.
  - BLANK is skipped.
- i_enable rising during BLANK or RAIL_DOWN is ignored until OFF is reached. Power-up then restarts the next cycle.
- i_enable is sampled directly; it is synchronous to i_pixel_clk.
- Video path is one register stage with a latency of 1 cycle, identical for syncs, de and colours.
  - Pass-through applies only while in ACTIVE, or while in BLANK before its frame start.
  - At all other times outputs hold their reset values.
  - Rails and reset come straight from state registers and have no extra latency.
- Colour expansion: output = MSB-aligned replication of the input, repeated until OUT_DEPTH bits, extra LSBs truncated.
  - 4→8: 0xA → 0xAA.
  - 5→8: 10110 → 10110101.
  - Equal depths: identity.
- Counter widths use $clog2 of max(STEP_CYCLES, RESET_CYCLES, BLANK_TIMEOUT)+1. Counters never wrap; they reload on every state change.
- Asynchronous reset mid-sequence drops all rails and reset within the same cycle. This is intentional emergency-off behaviour.

Decomposition:
- Shared package: state enum (OFF, RAIL_UP, RESET_HOLD, SETTLE, ACTIVE, BLANK, RAIL_DOWN) and a colour-replication function taking IN/OUT depths.
- One sub-module is natural: tft_colour_expand, a registered 3-channel replicator with a blank input. The power FSM stays in the parent.

Test Plan:
Common parameters: RAILS=5, STEP=4, RESET_CYCLES=8, SETTLE=2, IN=4, OUT=8, BLANK_TIMEOUT=20.
- Power-up: raise i_enable at cycle 0 → rails 00001, 00011, … 11111 at cycles 1, 5, 9, 13, 17. o_tft_reset_n rises at 25. Outputs stay blank until the second vsync fall. o_ready = 1 from that cycle.
- Colour path: in ACTIVE, drive R=0xA, G=0x3, B=0xF with de=1 → one cycle later R=0xAA, G=0x33, B=0xFF, de=1. Repeat with IN=5, input 0x16 → output 0xB5.
- Power-down: drop i_enable mid-frame → video continues to the next vsync fall, then blanks. Reset drops the same cycle. Rails go 01111, 00111, 00011, 00001, 00000 every 4 cycles.
- Abort: drop i_enable while rails = 00111 → reset stays 0. Rails go 00011, 00001, 00000 at +4, +8, +12. Re-raising enable at +2 has no effect until OFF, then power-up restarts.
- Missing vsync: hold i_vsync = 1, then drop i_enable in ACTIVE → BLANK exits after 20 cycles and the down-sequence proceeds.
- Asynchronous reset pulse during RESET_HOLD → all rails 0, reset 0, outputs blank immediately. The sequence restarts from cycle 1 after release if enable = 1.
